// File: rtl/c499_lock_pkg.sv
// c499_lock_pkg: types, defaults and helpers shared by the c499 key loader.
//   kl_state_t        key-loader FSM state encoding
//   C499_KEY_W        default key width (bits driving c499 s_0..s_{KEY_W-1})
//   C499_KEY_TIMEOUT  default idle-cycle budget while a load is in progress
//   kl_parity_odd()   returns 1 when shadow bits plus parity bit have odd parity
// Optional feature macro: C499_KEY_PARITY_EN adds the PAR state.
package c499_lock_pkg;

  localparam int C499_KEY_W       = 2;
  localparam int C499_KEY_TIMEOUT = 16;

  typedef enum logic [2:0] {
    KL_IDLE,
    KL_SHIFT,
`ifdef C499_KEY_PARITY_EN
    KL_PAR,
`endif
    KL_COMMIT,
    KL_ERR
  } kl_state_t;

  // Callers zero-extend the key into the 32-bit argument, so the unused
  // upper bits never disturb the XOR reduction.
  function automatic logic kl_parity_odd(input logic [31:0] bits, input logic par_bit);
    return (^bits) ^ par_bit;
  endfunction

endpackage

// File: rtl/c499_key_loader_if.sv
// c499_key_loader_if: serial key-load bus between a key source and the loader.
//   load_req   start/restart a key load (one-cycle pulse)
//   key_vld    bit strobe for key_si
//   key_si     serial key bit, LSB first
//   s_key      committed key driving c499 s_0..s_{KEY_W-1}
//   key_ready  committed key valid
//   busy       load in progress
//   load_err   last load failed (parity or timeout)
// Modports: master = key source, slave = key loader.
interface c499_key_loader_if #(
  parameter int KEY_W = 2
);

  logic             load_req;
  logic             key_vld;
  logic             key_si;
  logic [KEY_W-1:0] s_key;
  logic             key_ready;
  logic             busy;
  logic             load_err;

  modport master (
    output load_req, key_vld, key_si,
    input  s_key, key_ready, busy, load_err
  );

  modport slave (
    input  load_req, key_vld, key_si,
    output s_key, key_ready, busy, load_err
  );

endinterface

// File: rtl/c499_key_shreg.sv
// c499_key_shreg: indexed shadow register that collects the serial key.
//   clk     clock, rising edge
//   rst     synchronous active-high reset
//   clr     clear shadow and bit counter (start of a new load)
//   we      write bit_in into shadow[cnt] and advance cnt
//   bit_in  serial key bit
//   shadow  collected key bits
//   cnt     number of bits collected so far
module c499_key_shreg #(
  parameter int KEY_W = 2,
  parameter int CNT_W = $clog2(KEY_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic             bit_in,
  output logic [KEY_W-1:0] shadow,
  output logic [CNT_W-1:0] cnt
);

  // Writes stop once KEY_W bits are held so cnt can never index past the key.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (we && (cnt < CNT_W'(KEY_W))) begin
      for (int i = 0; i < KEY_W; i++) begin
        if (cnt == CNT_W'(i)) begin
          shadow[i] <= bit_in;
        end
      end
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/c499_key_loader.sv
// c499_key_loader: serial key-load controller in front of the key-gated c499.
// Shifts a key in LSB first, optionally checks an even-parity bit, then commits
// the key atomically onto s_key. Until a commit, s_key is 0 and key_ready is 0.
//   CK        clock, rising edge
//   RST       synchronous active-high reset, overrides every other input
//   bus       c499_key_loader_if slave modport (load_req, key_vld, key_si in;
//             s_key, key_ready, busy, load_err out; all outputs registered)
// Parameters: KEY_W key width, TIMEOUT consecutive idle cycles before error.
// Optional feature macro: C499_KEY_PARITY_EN (trailing parity bit, PAR state).
module c499_key_loader
  import c499_lock_pkg::*;
#(
  parameter int KEY_W   = C499_KEY_W,
  parameter int TIMEOUT = C499_KEY_TIMEOUT
) (
  input logic              CK,
  input logic              RST,
  c499_key_loader_if.slave bus
);

  localparam int CNT_W  = $clog2(KEY_W + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  kl_state_t         state;
  kl_state_t         state_nxt;
  logic [KEY_W-1:0]  s_key_q;
  logic [KEY_W-1:0]  s_key_nxt;
  logic              ready_q;
  logic              ready_nxt;
  logic              busy_q;
  logic              busy_nxt;
  logic              err_q;
  logic              err_nxt;
  logic [IDLE_W-1:0] idle_q;
  logic [IDLE_W-1:0] idle_nxt;
  logic              sh_clr;
  logic              sh_we;
  logic              to_err;
  logic [KEY_W-1:0]  shadow;
  logic [CNT_W-1:0]  cnt;

  c499_key_shreg #(
    .KEY_W (KEY_W),
    .CNT_W (CNT_W)
  ) u_shreg (
    .clk    (CK),
    .rst    (RST),
    .clr    (sh_clr),
    .we     (sh_we),
    .bit_in (bus.key_si),
    .shadow (shadow),
    .cnt    (cnt)
  );

  // State, committed key, status flags and idle counter.
  always_ff @(posedge CK) begin
    if (RST) begin
      state   <= KL_IDLE;
      s_key_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      idle_q  <= '0;
    end else begin
      state   <= state_nxt;
      s_key_q <= s_key_nxt;
      ready_q <= ready_nxt;
      busy_q  <= busy_nxt;
      err_q   <= err_nxt;
      idle_q  <= idle_nxt;
    end
  end

  // Next-state logic. load_req restarts from any state and beats a
  // simultaneous key_vld. The idle counter saturates at TIMEOUT; reaching
  // TIMEOUT-1 on another idle cycle means this is the TIMEOUT-th idle cycle.
  always_comb begin
    state_nxt = state;
    s_key_nxt = s_key_q;
    ready_nxt = ready_q;
    busy_nxt  = busy_q;
    err_nxt   = err_q;
    idle_nxt  = idle_q;
    sh_clr    = 1'b0;
    sh_we     = 1'b0;
    to_err    = 1'b0;

    if (bus.load_req) begin
      state_nxt = KL_SHIFT;
      sh_clr    = 1'b1;
      idle_nxt  = '0;
      s_key_nxt = '0;
      ready_nxt = 1'b0;
      err_nxt   = 1'b0;
      busy_nxt  = 1'b1;
    end else begin
      case (state)
        KL_SHIFT: begin
          if (bus.key_vld) begin
            sh_we    = 1'b1;
            idle_nxt = '0;
            if (cnt == CNT_W'(KEY_W - 1)) begin
`ifdef C499_KEY_PARITY_EN
              state_nxt = KL_PAR;
`else
              state_nxt = KL_COMMIT;
`endif
            end
          end else begin
            if (idle_q != IDLE_W'(TIMEOUT)) begin
              idle_nxt = idle_q + IDLE_W'(1);
            end
            if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
              to_err = 1'b1;
            end
          end
        end
`ifdef C499_KEY_PARITY_EN
        KL_PAR: begin
          if (bus.key_vld) begin
            idle_nxt = '0;
            if (kl_parity_odd(32'(shadow), bus.key_si)) begin
              to_err = 1'b1;
            end else begin
              state_nxt = KL_COMMIT;
            end
          end else begin
            if (idle_q != IDLE_W'(TIMEOUT)) begin
              idle_nxt = idle_q + IDLE_W'(1);
            end
            if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
              to_err = 1'b1;
            end
          end
        end
`endif
        KL_COMMIT: begin
          state_nxt = KL_IDLE;
          s_key_nxt = shadow;
          ready_nxt = 1'b1;
          busy_nxt  = 1'b0;
        end
        KL_IDLE, KL_ERR: begin
          state_nxt = state;
        end
        default: begin
          state_nxt = KL_IDLE;
        end
      endcase

      if (to_err) begin
        state_nxt = KL_ERR;
        err_nxt   = 1'b1;
        busy_nxt  = 1'b0;
        s_key_nxt = '0;
        ready_nxt = 1'b0;
      end
    end
  end

  assign bus.s_key     = s_key_q;
  assign bus.key_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.load_err  = err_q;

endmodule
